uart_tx_buffered: RTL and testbench

//  Parametrised UART transmit path: FIFO-buffered byte queue feeding a serialiser with configurable

---
 rtl/uart_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/uart_tx_buffered.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state encoding,
// parity helper and parameter legality check.
package uart_pkg;

    typedef logic [2:0] tx_state_t;

    localparam tx_state_t ST_IDLE   = 3'd0;
    localparam tx_state_t ST_START  = 3'd1;
    localparam tx_state_t ST_DATA   = 3'd2;
    localparam tx_state_t ST_PARITY = 3'd3;
    localparam tx_state_t ST_STOP   = 3'd4;

    localparam int unsigned MAX_DATA_BITS = 8;

    // Unused upper bits must arrive as zero so they do not disturb the reduction.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    function automatic bit params_valid(input int unsigned cpb, input int unsigned db,
                                        input int unsigned depth, input int unsigned pe,
                                        input int unsigned po, input int unsigned sb);
        return (cpb >= 2) && (db >= 5) && (db <= MAX_DATA_BITS) &&
               (depth >= 2) && ((depth & (depth - 1)) == 0) &&
               (pe <= 1) && (po <= 1) && (sb >= 1) && (sb <= 2);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered not-full/empty/count flags; head is
// visible combinationally so a pop consumes it in one cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_push,
    input  logic [WIDTH-1:0]               i_push_data,
    input  logic                           i_pop,
    output logic [WIDTH-1:0]               o_head,
    output logic                           o_not_full,
    output logic                           o_empty,
    output logic [$clog2(DEPTH+1)-1:0]     o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nx;
    logic             r_not_full;
    logic             r_empty;
    logic             w_push_acc;
    logic             w_pop_acc;

    // Acceptance uses only registered flags; a same-edge pop never frees a slot.
    assign w_push_acc = i_push && r_not_full;
    assign w_pop_acc  = i_pop && !r_empty;

    always_comb begin
        w_count_nx = r_count;
        case ({w_push_acc, w_pop_acc})
            2'b10:   w_count_nx = r_count + CNT_W'(1);
            2'b01:   w_count_nx = r_count - CNT_W'(1);
            default: w_count_nx = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_not_full <= 1'b1;
            r_empty    <= 1'b1;
        end else begin
            if (w_push_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count    <= w_count_nx;
            r_not_full <= (w_count_nx != CNT_W'(DEPTH));
            r_empty    <= (w_count_nx == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_acc) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head     = r_mem[r_rd_ptr];
    assign o_not_full = r_not_full;
    assign o_empty    = r_empty;
    assign o_count    = r_count;

endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter with configurable data width, optional
// parity and 1/2 stop bits; queued frames are sent back-to-back.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 100,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_valid,
    input  logic [DATA_BITS-1:0]              wr_data,
    output logic                              wr_ready,
    input  logic                              clr_ovf,
    output logic                              overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              tx_busy,
    output logic                              tx_done,
    output logic                              tx_serial
);

    localparam int unsigned STOP_CYCLES = STOP_BITS * CLKS_PER_BIT;
    localparam int unsigned BAUD_W      = $clog2(STOP_CYCLES);
    localparam int unsigned BIT_W       = $clog2(DATA_BITS);

    if (!params_valid(CLKS_PER_BIT, DATA_BITS, FIFO_DEPTH, PARITY_EN, PARITY_ODD, STOP_BITS)) begin : g_bad_params
        $error("uart_tx_buffered: parameter out of range");
    end

    tx_state_t              r_state, w_state_nx;
    logic [BAUD_W-1:0]      r_baud, w_baud_nx;
    logic [BIT_W-1:0]       r_bit_idx, w_bit_nx;
    logic [DATA_BITS-1:0]   r_shift, w_shift_nx;
    logic                   r_parity, w_parity_nx;
    logic                   r_tx_serial, w_serial_nx;
    logic                   r_tx_done, w_done_nx;
    logic                   r_tx_busy;
    logic                   r_overflow;
    logic                   w_start_frame;
    logic                   w_fifo_empty;
    logic [DATA_BITS-1:0]   w_head;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (wr_valid),
        .i_push_data (wr_data),
        .i_pop       (w_start_frame),
        .o_head      (w_head),
        .o_not_full  (wr_ready),
        .o_empty     (w_fifo_empty),
        .o_count     (fifo_count)
    );

    // Next-state and next-output decode; w_start_frame doubles as the FIFO pop.
    always_comb begin
        w_state_nx    = r_state;
        w_baud_nx     = r_baud + BAUD_W'(1);
        w_bit_nx      = r_bit_idx;
        w_shift_nx    = r_shift;
        w_parity_nx   = r_parity;
        w_serial_nx   = r_tx_serial;
        w_done_nx     = 1'b0;
        w_start_frame = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_baud_nx     = '0;
                w_serial_nx   = 1'b1;
                w_start_frame = !w_fifo_empty;
            end
            ST_START: begin
                if (r_baud == BAUD_W'(CLKS_PER_BIT - 1)) begin
                    w_state_nx  = ST_DATA;
                    w_baud_nx   = '0;
                    w_bit_nx    = '0;
                    w_serial_nx = r_shift[0];
                end
            end
            ST_DATA: begin
                if (r_baud == BAUD_W'(CLKS_PER_BIT - 1)) begin
                    w_baud_nx = '0;
                    if (r_bit_idx == BIT_W'(DATA_BITS - 1)) begin
                        if (PARITY_EN != 0) begin
                            w_state_nx  = ST_PARITY;
                            w_serial_nx = r_parity;
                        end else begin
                            w_state_nx  = ST_STOP;
                            w_serial_nx = 1'b1;
                        end
                    end else begin
                        w_bit_nx    = r_bit_idx + BIT_W'(1);
                        w_shift_nx  = r_shift >> 1;
                        w_serial_nx = r_shift[1];
                    end
                end
            end
            ST_PARITY: begin
                if (r_baud == BAUD_W'(CLKS_PER_BIT - 1)) begin
                    w_state_nx  = ST_STOP;
                    w_baud_nx   = '0;
                    w_serial_nx = 1'b1;
                end
            end
            ST_STOP: begin
                // Registered pulse lands on the final stop cycle.
                w_done_nx = (r_baud == BAUD_W'(STOP_CYCLES - 2));
                if (r_baud == BAUD_W'(STOP_CYCLES - 1)) begin
                    w_state_nx    = ST_IDLE;
                    w_baud_nx     = '0;
                    w_serial_nx   = 1'b1;
                    w_start_frame = !w_fifo_empty;
                end
            end
            default: begin
                w_state_nx  = ST_IDLE;
                w_baud_nx   = '0;
                w_serial_nx = 1'b1;
            end
        endcase

        if (w_start_frame) begin
            w_state_nx  = ST_START;
            w_baud_nx   = '0;
            w_shift_nx  = w_head;
            w_parity_nx = parity_bit(MAX_DATA_BITS'(w_head), PARITY_ODD != 0);
            w_serial_nx = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_baud      <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_tx_serial <= 1'b1;
            r_tx_done   <= 1'b0;
            r_tx_busy   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_baud      <= w_baud_nx;
            r_bit_idx   <= w_bit_nx;
            r_shift     <= w_shift_nx;
            r_parity    <= w_parity_nx;
            r_tx_serial <= w_serial_nx;
            r_tx_done   <= w_done_nx;
            r_tx_busy   <= (w_state_nx != ST_IDLE);
        end
    end

    // Sticky overflow; a rejected push outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (wr_valid && !wr_ready) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign overflow  = r_overflow;
    assign tx_busy   = r_tx_busy;
    assign tx_done   = r_tx_done;
    assign tx_serial = r_tx_serial;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: four instances cover the default
// frame, even/odd parity and the 7-bit / 2-stop format.
module tb_uart_tx_buffered;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic       a_wr_valid, a_clr_ovf, a_wr_ready, a_overflow, a_tx_busy, a_tx_done, a_tx_serial;
    logic [7:0] a_wr_data;
    logic [2:0] a_fifo_count;
    logic       e_wr_valid, e_clr_ovf, e_wr_ready, e_overflow, e_tx_busy, e_tx_done, e_tx_serial;
    logic [7:0] e_wr_data;
    logic [2:0] e_fifo_count;
    logic       o_wr_valid, o_clr_ovf, o_wr_ready, o_overflow, o_tx_busy, o_tx_done, o_tx_serial;
    logic [7:0] o_wr_data;
    logic [2:0] o_fifo_count;
    logic       s_wr_valid, s_clr_ovf, s_wr_ready, s_overflow, s_tx_busy, s_tx_done, s_tx_serial;
    logic [6:0] s_wr_data;
    logic [2:0] s_fifo_count;

    uart_tx_buffered #(.CLKS_PER_BIT(4), .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .wr_valid(a_wr_valid), .wr_data(a_wr_data), .wr_ready(a_wr_ready),
        .clr_ovf(a_clr_ovf), .overflow(a_overflow), .fifo_count(a_fifo_count),
        .tx_busy(a_tx_busy), .tx_done(a_tx_done), .tx_serial(a_tx_serial));

    uart_tx_buffered #(.CLKS_PER_BIT(4), .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_e (
        .clk(clk), .rst(rst), .wr_valid(e_wr_valid), .wr_data(e_wr_data), .wr_ready(e_wr_ready),
        .clr_ovf(e_clr_ovf), .overflow(e_overflow), .fifo_count(e_fifo_count),
        .tx_busy(e_tx_busy), .tx_done(e_tx_done), .tx_serial(e_tx_serial));

    uart_tx_buffered #(.CLKS_PER_BIT(4), .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_o (
        .clk(clk), .rst(rst), .wr_valid(o_wr_valid), .wr_data(o_wr_data), .wr_ready(o_wr_ready),
        .clr_ovf(o_clr_ovf), .overflow(o_overflow), .fifo_count(o_fifo_count),
        .tx_busy(o_tx_busy), .tx_done(o_tx_done), .tx_serial(o_tx_serial));

    uart_tx_buffered #(.CLKS_PER_BIT(4), .DATA_BITS(7), .FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_s (
        .clk(clk), .rst(rst), .wr_valid(s_wr_valid), .wr_data(s_wr_data), .wr_ready(s_wr_ready),
        .clr_ovf(s_clr_ovf), .overflow(s_overflow), .fifo_count(s_fifo_count),
        .tx_busy(s_tx_busy), .tx_done(s_tx_done), .tx_serial(s_tx_serial));

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (a_tx_serial !== 1'b1) begin n_fail++; $display("FAIL rst_serial got=%b exp=1", a_tx_serial); end
        n_checks++; if (a_wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%b exp=1", a_wr_ready); end
        n_checks++; if (a_fifo_count !== 3'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", a_fifo_count); end
        n_checks++; if ({a_tx_busy, a_tx_done, a_overflow} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got=%b exp=000", {a_tx_busy, a_tx_done, a_overflow}); end
        n_checks++; if ({e_tx_serial, e_wr_ready, e_tx_busy, e_tx_done, e_overflow, e_fifo_count} !== 8'b11000000) begin n_fail++; $display("FAIL rst_even got=%b exp=11000000", {e_tx_serial, e_wr_ready, e_tx_busy, e_tx_done, e_overflow, e_fifo_count}); end
        n_checks++; if ({o_tx_serial, o_wr_ready, o_tx_busy, o_tx_done, o_overflow, o_fifo_count} !== 8'b11000000) begin n_fail++; $display("FAIL rst_odd got=%b exp=11000000", {o_tx_serial, o_wr_ready, o_tx_busy, o_tx_done, o_overflow, o_fifo_count}); end
        n_checks++; if ({s_tx_serial, s_wr_ready, s_tx_busy, s_tx_done, s_overflow, s_fifo_count} !== 8'b11000000) begin n_fail++; $display("FAIL rst_seven got=%b exp=11000000", {s_tx_serial, s_wr_ready, s_tx_busy, s_tx_done, s_overflow, s_fifo_count}); end
        rst = 1'b0;
    endtask

    // 0xA5 framed: start 0, data LSB-first 1,0,1,0,0,1,0,1, stop 1 (bit 0 sent first).
    task automatic test_single_frame();
        logic [9:0] exp_bits = 10'b1101001010;
        int dones = 0;
        for (int c = 0; c < 46; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_checks++; if (a_fifo_count !== 3'd1 || a_tx_serial !== 1'b1) begin n_fail++; $display("FAIL t1_queued count=%0d serial=%b exp 1/1", a_fifo_count, a_tx_serial); end
            end
            if (c >= 2 && c < 42) begin
                n_checks++; if (a_tx_serial !== exp_bits[4'((c - 2) / 4)]) begin n_fail++; $display("FAIL t1_serial c=%0d got=%b exp=%b", c, a_tx_serial, exp_bits[4'((c - 2) / 4)]); end
                n_checks++; if (a_tx_done !== (c == 41)) begin n_fail++; $display("FAIL t1_done c=%0d got=%b", c, a_tx_done); end
            end
            if (a_tx_done === 1'b1) dones++;
            if (c == 43) begin
                n_checks++; if (a_tx_busy !== 1'b0 || a_tx_serial !== 1'b1) begin n_fail++; $display("FAIL t1_idle busy=%b serial=%b exp 0/1", a_tx_busy, a_tx_serial); end
            end
            a_wr_valid = (c == 0);
            a_wr_data  = 8'hA5;
        end
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL t1_done_count got=%0d exp=1", dones); end
    endtask

    // 0x07 has three ones: even parity bit 1, odd parity bit 0; 11-bit frame.
    task automatic test_parity();
        logic [10:0] exp_e = 11'b11000001110;
        logic [10:0] exp_o = 11'b10000001110;
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            if (c >= 2 && c < 46) begin
                n_checks++; if (e_tx_serial !== exp_e[4'((c - 2) / 4)]) begin n_fail++; $display("FAIL t2_even c=%0d got=%b exp=%b", c, e_tx_serial, exp_e[4'((c - 2) / 4)]); end
                n_checks++; if (o_tx_serial !== exp_o[4'((c - 2) / 4)]) begin n_fail++; $display("FAIL t2_odd c=%0d got=%b exp=%b", c, o_tx_serial, exp_o[4'((c - 2) / 4)]); end
                n_checks++; if (e_tx_done !== (c == 45) || o_tx_done !== (c == 45)) begin n_fail++; $display("FAIL t2_done c=%0d even=%b odd=%b", c, e_tx_done, o_tx_done); end
            end
            if (c == 47) begin
                n_checks++; if (e_tx_busy !== 1'b0 || o_tx_busy !== 1'b0) begin n_fail++; $display("FAIL t2_idle even=%b odd=%b exp 0/0", e_tx_busy, o_tx_busy); end
            end
            e_wr_valid = (c == 0); e_wr_data = 8'h07;
            o_wr_valid = (c == 0); o_wr_data = 8'h07;
        end
    endtask

    task automatic test_burst_overflow();
        logic [7:0] bytes [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        logic [9:0] f;
        int dones = 0;
        for (int c = 0; c < 216; c++) begin
            @(negedge clk);
            if (c == 6) begin
                n_checks++; if (a_overflow !== 1'b1) begin n_fail++; $display("FAIL t3_ovf_set got=%b exp=1", a_overflow); end
                n_checks++; if (a_fifo_count !== 3'd4 || a_wr_ready !== 1'b0) begin n_fail++; $display("FAIL t3_full count=%0d ready=%b exp 4/0", a_fifo_count, a_wr_ready); end
            end
            if (c >= 2 && c < 202) begin
                f = {1'b1, bytes[3'((c - 2) / 40)], 1'b0};
                n_checks++; if (a_tx_serial !== f[4'(((c - 2) % 40) / 4)]) begin n_fail++; $display("FAIL t3_serial c=%0d got=%b exp=%b", c, a_tx_serial, f[4'(((c - 2) % 40) / 4)]); end
                n_checks++; if (a_tx_done !== (((c - 2) % 40) == 39)) begin n_fail++; $display("FAIL t3_done c=%0d got=%b", c, a_tx_done); end
            end
            if (a_tx_done === 1'b1) dones++;
            if (c == 205) begin
                n_checks++; if (a_tx_busy !== 1'b0 || a_tx_serial !== 1'b1 || a_fifo_count !== 3'd0) begin n_fail++; $display("FAIL t3_drained busy=%b serial=%b count=%0d exp 0/1/0", a_tx_busy, a_tx_serial, a_fifo_count); end
            end
            if (c == 209) begin
                n_checks++; if (a_overflow !== 1'b1) begin n_fail++; $display("FAIL t3_ovf_sticky got=%b exp=1", a_overflow); end
            end
            if (c == 211) begin
                n_checks++; if (a_overflow !== 1'b0) begin n_fail++; $display("FAIL t3_ovf_clr got=%b exp=0", a_overflow); end
            end
            a_wr_valid = (c <= 5);
            a_wr_data  = (c <= 5) ? bytes[3'(c)] : 8'h00;
            a_clr_ovf  = (c == 5) || (c == 210);
        end
        n_checks++; if (dones != 5) begin n_fail++; $display("FAIL t3_done_count got=%0d exp=5", dones); end
    endtask

    task automatic test_push_on_pop();
        logic [7:0] bytes [5] = '{8'h5A, 8'h01, 8'h02, 8'h03, 8'h04};
        logic [9:0] f;
        int dones = 0;
        for (int c = 0; c < 216; c++) begin
            @(negedge clk);
            if (c == 5 || c == 41) begin
                n_checks++; if (a_fifo_count !== 3'd4 || a_wr_ready !== 1'b0) begin n_fail++; $display("FAIL t4_full c=%0d count=%0d ready=%b exp 4/0", c, a_fifo_count, a_wr_ready); end
            end
            if (c == 42) begin
                n_checks++; if (a_fifo_count !== 3'd3) begin n_fail++; $display("FAIL t4_count got=%0d exp=3", a_fifo_count); end
                n_checks++; if (a_overflow !== 1'b1) begin n_fail++; $display("FAIL t4_ovf got=%b exp=1", a_overflow); end
            end
            if (c >= 2 && c < 202) begin
                f = {1'b1, bytes[3'((c - 2) / 40)], 1'b0};
                n_checks++; if (a_tx_serial !== f[4'(((c - 2) % 40) / 4)]) begin n_fail++; $display("FAIL t4_serial c=%0d got=%b exp=%b", c, a_tx_serial, f[4'(((c - 2) % 40) / 4)]); end
            end
            if (a_tx_done === 1'b1) dones++;
            if (c == 205) begin
                n_checks++; if (a_tx_busy !== 1'b0 || a_tx_serial !== 1'b1 || a_fifo_count !== 3'd0) begin n_fail++; $display("FAIL t4_drained busy=%b serial=%b count=%0d exp 0/1/0", a_tx_busy, a_tx_serial, a_fifo_count); end
            end
            a_wr_valid = (c <= 4) || (c == 41);
            a_wr_data  = (c <= 4) ? bytes[3'(c)] : 8'h99;
            a_clr_ovf  = (c == 210);
        end
        n_checks++; if (dones != 5) begin n_fail++; $display("FAIL t4_done_count got=%0d exp=5", dones); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] bytes [3] = '{8'h3C, 8'h81, 8'h7E};
        int bad = 0;
        for (int c = 0; c < 114; c++) begin
            @(negedge clk);
            if (c == 12) begin
                n_checks++; if (a_tx_busy !== 1'b1 || a_fifo_count !== 3'd2 || a_tx_serial !== 1'b0) begin n_fail++; $display("FAIL t5_pre busy=%b count=%0d serial=%b exp 1/2/0", a_tx_busy, a_fifo_count, a_tx_serial); end
            end
            if (c == 13) begin
                n_checks++; if (a_tx_serial !== 1'b1) begin n_fail++; $display("FAIL t5_serial got=%b exp=1", a_tx_serial); end
                n_checks++; if (a_fifo_count !== 3'd0 || a_tx_busy !== 1'b0) begin n_fail++; $display("FAIL t5_flush count=%0d busy=%b exp 0/0", a_fifo_count, a_tx_busy); end
                n_checks++; if (a_wr_ready !== 1'b1 || a_tx_done !== 1'b0) begin n_fail++; $display("FAIL t5_flags ready=%b done=%b exp 1/0", a_wr_ready, a_tx_done); end
            end
            if (c > 13 && (a_tx_serial !== 1'b1 || a_tx_busy !== 1'b0 || a_tx_done !== 1'b0)) bad++;
            a_wr_valid = (c <= 2);
            a_wr_data  = (c <= 2) ? bytes[2'(c)] : 8'h00;
            rst        = (c == 12);
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL t5_quiet active_cycles=%0d exp=0", bad); end
    endtask

    // 0x41 on 7 bits: start 0, data 1,0,0,0,0,0,1, two stop bits (bit 0 sent first).
    task automatic test_seven_two_stop();
        logic [9:0] exp_bits = 10'b1110000010;
        int dones = 0;
        for (int c = 0; c < 46; c++) begin
            @(negedge clk);
            if (c >= 2 && c < 42) begin
                n_checks++; if (s_tx_serial !== exp_bits[4'((c - 2) / 4)]) begin n_fail++; $display("FAIL t6_serial c=%0d got=%b exp=%b", c, s_tx_serial, exp_bits[4'((c - 2) / 4)]); end
                n_checks++; if (s_tx_done !== (c == 41)) begin n_fail++; $display("FAIL t6_done c=%0d got=%b", c, s_tx_done); end
            end
            if (s_tx_done === 1'b1) dones++;
            if (c == 43) begin
                n_checks++; if (s_tx_busy !== 1'b0) begin n_fail++; $display("FAIL t6_idle busy=%b exp=0", s_tx_busy); end
            end
            s_wr_valid = (c == 0);
            s_wr_data  = 7'h41;
        end
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL t6_done_count got=%0d exp=1", dones); end
    endtask

    initial begin
        rst = 1'b1;
        a_wr_valid = 1'b0; a_wr_data = 8'h00; a_clr_ovf = 1'b0;
        e_wr_valid = 1'b0; e_wr_data = 8'h00; e_clr_ovf = 1'b0;
        o_wr_valid = 1'b0; o_wr_data = 8'h00; o_clr_ovf = 1'b0;
        s_wr_valid = 1'b0; s_wr_data = 7'h00; s_clr_ovf = 1'b0;
        test_reset();
        test_single_frame();
        test_parity();
        test_burst_overflow();
        test_push_on_pop();
        test_reset_mid_frame();
        test_seven_two_stop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
